// File: rtl/sub_bit.sv
// One-bit full subtractor: the ripple element of the sub borrow chain.
module sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of x - y - bin
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub.sv
// Parameterised subtractor: combinational diff/borrow/zero/ovf of a - b,
// plus a one-cycle registered copy of diff and borrow with valid tracking.
module sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] diff_q,
    output logic             borrow_q,
    output logic             out_valid
);

    // borrow_chain[0] is the borrow into the LSB; the top entry is the final borrow
    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_q_reg;
    logic             borrow_q_reg;
    logic             out_valid_reg;

    assign borrow_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            sub_bit u_bit (
                .x    (a[gi]),
                .y    (b[gi]),
                .bin  (borrow_chain[gi]),
                .d    (diff[gi]),
                .bout (borrow_chain[gi+1])
            );
        end
    endgenerate

    // Flags derived from the ripple result; ovf flags a sign change that
    // cannot happen when a and b already share a sign.
    assign borrow = borrow_chain[WIDTH];
    assign zero   = (diff == '0);
    assign ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // Registered stage: capture on in_valid, hold otherwise; reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q_reg    <= '0;
            borrow_q_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                diff_q_reg   <= diff;
                borrow_q_reg <= borrow;
            end
        end
    end

    assign diff_q    = diff_q_reg;
    assign borrow_q  = borrow_q_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sub.sv
// Self-checking bench for sub at WIDTH=4: arithmetic model plus directed literals.
module tb_sub;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;
    logic [W-1:0] diff_q;
    logic         borrow_q;
    logic         out_valid;

    int n_vec  = 0;
    int n_fail = 0;

    // Registered-stage model state
    bit model_known = 0;
    int exp_dq      = 0;
    int exp_bq      = 0;
    int exp_ov      = 0;

    sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf),
        .diff_q    (diff_q),
        .borrow_q  (borrow_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s a=%0d b=%0d actual=%0h required=%0h", name, a, b, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers
    function automatic int m_diff(input int x, input int y);
        return (x - y + MOD) % MOD;
    endfunction

    function automatic int m_signed(input int x);
        return (x > SMAX) ? x - MOD : x;
    endfunction

    function automatic int m_ovf(input int x, input int y);
        int s;
        s = m_signed(x) - m_signed(y);
        return (s > SMAX || s < SMIN) ? 1 : 0;
    endfunction

    // Compare process: advance the model at each edge, then check every output
    always @(posedge clk) begin
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        if (rst) begin
            model_known = 1;
            exp_dq = 0;
            exp_bq = 0;
            exp_ov = 0;
        end else if (model_known) begin
            exp_ov = int'(in_valid);
            if (in_valid) begin
                exp_dq = m_diff(ia, ib);
                exp_bq = (ia < ib) ? 1 : 0;
            end
        end
        #1;
        ia = int'(a);
        ib = int'(b);
        chk("diff",   32'(diff),   32'(m_diff(ia, ib)));
        chk("borrow", 32'(borrow), 32'((ia < ib) ? 1 : 0));
        chk("zero",   32'(zero),   32'((ia == ib) ? 1 : 0));
        chk("ovf",    32'(ovf),    32'(m_ovf(ia, ib)));
        if (model_known) begin
            chk("diff_q",    32'(diff_q),    32'(exp_dq));
            chk("borrow_q",  32'(borrow_q),  32'(exp_bq));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
        end
    end

    // Apply operands away from the edge and check hand-computed combinational values
    task automatic lit(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] ed, input logic eb, input logic ez, input logic eo);
        @(negedge clk);
        a = ta;
        b = tb;
        #4;
        chk("lit_diff",   32'(diff),   32'(ed));
        chk("lit_borrow", 32'(borrow), 32'(eb));
        chk("lit_zero",   32'(zero),   32'(ez));
        chk("lit_ovf",    32'(ovf),    32'(eo));
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;

        // Combinational literals (independent of rst)
        lit(4'b0110, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0);
        lit(4'b0010, 4'b0111, 4'b1011, 1'b1, 1'b0, 1'b0);
        lit(4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0);
        lit(4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0);
        lit(4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b0, 1'b1);
        lit(4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1);
        lit(4'b1011, 4'b0000, 4'b1011, 1'b0, 1'b0, 1'b0);

        // Reset for two edges
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_diff_q",    32'(diff_q),    32'(0));
        chk("rst_borrow_q",  32'(borrow_q),  32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));

        // One-cycle capture
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = 4'b0010;
        b        = 4'b0111;
        @(posedge clk);
        #1;
        chk("cap_diff_q",    32'(diff_q),    32'(4'b1011));
        chk("cap_borrow_q",  32'(borrow_q),  32'(1));
        chk("cap_out_valid", 32'(out_valid), 32'(1));

        // Hold when in_valid is low
        @(negedge clk);
        in_valid = 1'b0;
        a        = 4'b0101;
        b        = 4'b0001;
        @(posedge clk);
        #1;
        chk("hold_diff_q",    32'(diff_q),    32'(4'b1011));
        chk("hold_borrow_q",  32'(borrow_q),  32'(1));
        chk("hold_out_valid", 32'(out_valid), 32'(0));

        // Exhaustive sweep with a mixed valid pattern
        for (int i = 0; i < MOD * MOD; i++) begin
            @(negedge clk);
            a        = W'(i / MOD);
            b        = W'(i % MOD);
            in_valid = ((i % 3) != 0);
        end

        // Reset mid-stream overrides in_valid
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'b1001;
        b        = 4'b0010;
        @(negedge clk);
        rst      = 1'b1;
        a        = 4'b0011;
        b        = 4'b0001;
        @(posedge clk);
        #1;
        chk("midrst_diff_q",    32'(diff_q),    32'(0));
        chk("midrst_borrow_q",  32'(borrow_q),  32'(0));
        chk("midrst_out_valid", 32'(out_valid), 32'(0));

        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
